execute_iterative_unit: RTL and testbench

Parametrised execute-stage unit that extends single-cycle ALU execution with iterative multiply/divide and architectural HI/LO registers. It sits between decode and memory/writeback. It accepts one operation per valid/ready handshake and returns a registered result with a valid/ready handshake. Single-cycle ops complete in one cycle; MULT/MULTU/DIV/DIVU occupy the unit for WIDTH+1 cycles and stall upstream through `in_ready`.

---
 rtl/execute_iterative_unit.sv | 178 +++++++++++++++++
 tb/tb_execute_iterative_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_iterative_unit.sv
// Execute stage: single-cycle ALU ops plus iterative MULT/MULTU/DIV/DIVU with HI/LO registers.
// Latency: ALU/MFxx/MTxx 1 cycle; mul/div WIDTH+1 cycles (WIDTH BUSY iterations + FIX).
// Backpressure: in_ready drops while iterating or while a result is held with out_ready low.
module execute_iterative_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ovf_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf,
  output logic             out_div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4,  OP_NOR  = 4'd5,  OP_SLT  = 4'd6,  OP_SLTU = 4'd7;
  localparam logic [3:0] OP_MFHI = 4'd12, OP_MFLO = 4'd13, OP_MTHI = 4'd14, OP_MTLO = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               accept, is_iter, op_signed;
  logic               is_div, neg_q, neg_r, div0;
  logic [WIDTH-1:0]   a_mag, b_mag, b_mag_r, a_save;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   rem, quo, q_fix, r_fix;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   sum_add, sum_sub, alu_res;
  logic               alu_ovf;

  assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign is_iter   = (in_op[3:2] == 2'b10);
  // MULT and DIV are the even codes of the 8..11 group
  assign op_signed = !in_op[0];
  assign a_mag     = (op_signed && in_a[WIDTH-1]) ? -in_a : in_a;
  assign b_mag     = (op_signed && in_b[WIDTH-1]) ? -in_b : in_b;

  // One shift-add step: add multiplicand into the upper half when the low bit is set, then shift right
  assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, b_mag_r} : '0);
  // One restoring-division step: bring down the next dividend bit and trial-subtract
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, b_mag_r});
  assign div_diff  = div_shift - {1'b0, b_mag_r};

  assign prod_fix  = neg_q ? -prod : prod;
  assign q_fix     = neg_q ? -quo : quo;
  assign r_fix     = neg_r ? -rem : rem;

  assign sum_add   = in_a + in_b;
  assign sum_sub   = in_a - in_b;

  // Single-cycle ALU result and signed-overflow detection
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (in_op)
      OP_ADD: begin
        alu_res = sum_add;
        alu_ovf = in_ovf_en && (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum_add[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sum_sub;
        alu_ovf = in_ovf_en && (in_a[WIDTH-1] != in_b[WIDTH-1]) && (sum_sub[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_NOR:  alu_res = ~(in_a | in_b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: flush aborts anything in flight and drops a simultaneous accept
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept && is_iter) state_nxt = S_BUSY;
        S_BUSY:  if (cnt == CNT_W'(1)) state_nxt = S_FIX;
        S_FIX:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Iteration datapath; contents are don't-care outside BUSY/FIX so no reset is needed
  always_ff @(posedge clk) begin
    if (accept && is_iter) begin
      prod    <= {{WIDTH{1'b0}}, a_mag};
      rem     <= '0;
      quo     <= a_mag;
      b_mag_r <= b_mag;
      a_save  <= in_a;
      is_div  <= in_op[1];
      neg_q   <= op_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
      neg_r   <= op_signed && in_a[WIDTH-1];
      div0    <= in_op[1] && (in_b == '0);
      cnt     <= CNT_W'(WIDTH);
    end else if (state == S_BUSY) begin
      cnt <= cnt - CNT_W'(1);
      if (is_div) begin
        rem <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], div_ge};
      end else begin
        prod <= {mul_sum, prod[WIDTH-1:1]};
      end
    end
  end

  // Output register and architectural HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_ovf    <= 1'b0;
      out_div0   <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ovf   <= 1'b0;
      out_div0  <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (accept && !is_iter) begin
        out_valid  <= 1'b1;
        out_result <= alu_res;
        out_ovf    <= alu_ovf;
        out_div0   <= 1'b0;
        if (in_op == OP_MTHI) hi <= in_a;
        if (in_op == OP_MTLO) lo <= in_a;
      end
      if (state == S_FIX) begin
        out_valid  <= 1'b1;
        out_result <= '0;
        out_ovf    <= 1'b0;
        out_div0   <= div0;
        if (!is_div) begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end else if (div0) begin
          hi <= a_save;
          lo <= '1;
        end else begin
          hi <= r_fix;
          lo <= q_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_execute_iterative_unit.sv
// Directed bench for execute_iterative_unit at WIDTH=32.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Each scenario task does its own comparisons against hand-computed values.
module tb_execute_iterative_unit;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, in_ovf_en;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b, out_result, hi, lo;
  logic        out_valid, out_ready, out_ovf, out_div0;
  int checks = 0;
  int errors = 0;

  execute_iterative_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_ovf_en(in_ovf_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_ovf(out_ovf), .out_div0(out_div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op, wait (bounded) for acceptance, then for in_ready to return.
  // lat = number of samples with in_ready low after the accept edge.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic oe, output int lat);
    int guard;
    in_op = op; in_a = a; in_b = b; in_ovf_en = oe; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin tick(); guard++; end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!in_ready && lat < 100) begin tick(); lat++; end
    checks++;
    if (guard >= 100 || lat >= 100) begin
      errors++;
      $display("FAIL do_op_timeout op=%0d accept_wait=%0d busy=%0d required <100", op, guard, lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_a = '0; in_b = '0;
    in_ovf_en = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checks++;
    if ({out_valid, out_ovf, out_div0, in_ready} !== 4'b0001) begin
      errors++; $display("FAIL reset_flags got=%b required=0001", {out_valid, out_ovf, out_div0, in_ready});
    end
    checks++;
    if ({out_result, hi, lo} !== 96'h0) begin
      errors++; $display("FAIL reset_regs result=%h hi=%h lo=%h required 0", out_result, hi, lo);
    end
  endtask

  task automatic test_add_ovf();
    int lat;
    do_op(4'd0, 32'h7FFFFFFF, 32'h1, 1'b1, lat);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h80000000 || out_ovf !== 1'b1) begin
      errors++; $display("FAIL add_ovf v=%b res=%h ovf=%b required 1 80000000 1", out_valid, out_result, out_ovf);
    end
    do_op(4'd0, 32'h7FFFFFFF, 32'h1, 1'b0, lat);
    checks++;
    if (out_result !== 32'h80000000 || out_ovf !== 1'b0) begin
      errors++; $display("FAIL add_noovf res=%h ovf=%b required 80000000 0", out_result, out_ovf);
    end
    do_op(4'd1, 32'h80000000, 32'h1, 1'b1, lat);
    checks++;
    if (out_result !== 32'h7FFFFFFF || out_ovf !== 1'b1) begin
      errors++; $display("FAIL sub_ovf res=%h ovf=%b required 7FFFFFFF 1", out_result, out_ovf);
    end
    do_op(4'd6, 32'hFFFFFFFF, 32'h1, 1'b0, lat);
    checks++;
    if (out_result !== 32'h1) begin
      errors++; $display("FAIL slt res=%h required 1", out_result);
    end
    do_op(4'd7, 32'hFFFFFFFF, 32'h1, 1'b0, lat);
    checks++;
    if (out_result !== 32'h0) begin
      errors++; $display("FAIL sltu res=%h required 0", out_result);
    end
  endtask

  task automatic test_mult();
    int lat;
    do_op(4'd8, 32'hFFFFFFFE, 32'h3, 1'b0, lat);
    checks++;
    if (lat != 33) begin
      errors++; $display("FAIL mult_latency got=%0d required=33", lat);
    end
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA || out_valid !== 1'b1 || out_result !== 32'h0) begin
      errors++; $display("FAIL mult hi=%h lo=%h v=%b res=%h required FFFFFFFF FFFFFFFA 1 0", hi, lo, out_valid, out_result);
    end
    do_op(4'd9, 32'hFFFFFFFE, 32'h3, 1'b0, lat);
    checks++;
    if (hi !== 32'h2 || lo !== 32'hFFFFFFFA) begin
      errors++; $display("FAIL multu hi=%h lo=%h required 00000002 FFFFFFFA", hi, lo);
    end
    do_op(4'd12, 32'h0, 32'h0, 1'b0, lat);
    checks++;
    if (out_result !== 32'h2) begin
      errors++; $display("FAIL mfhi_after_mul res=%h required 00000002", out_result);
    end
  endtask

  task automatic test_div();
    int lat;
    do_op(4'd10, 32'hFFFFFFF9, 32'h2, 1'b0, lat);
    checks++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF || out_div0 !== 1'b0) begin
      errors++; $display("FAIL div_neg lo=%h hi=%h div0=%b required FFFFFFFD FFFFFFFF 0", lo, hi, out_div0);
    end
    do_op(4'd10, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat);
    checks++;
    if (lo !== 32'h80000000 || hi !== 32'h0) begin
      errors++; $display("FAIL div_min lo=%h hi=%h required 80000000 0", lo, hi);
    end
    do_op(4'd11, 32'h5, 32'h0, 1'b0, lat);
    checks++;
    if (lo !== 32'hFFFFFFFF || hi !== 32'h5 || out_div0 !== 1'b1 || lat != 33) begin
      errors++; $display("FAIL divu_zero lo=%h hi=%h div0=%b lat=%0d required FFFFFFFF 5 1 33", lo, hi, out_div0, lat);
    end
    do_op(4'd11, 32'd100, 32'd7, 1'b0, lat);
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2 || out_div0 !== 1'b0) begin
      errors++; $display("FAIL divu lo=%h hi=%h div0=%b required E 2 0", lo, hi, out_div0);
    end
  endtask

  task automatic test_backpressure();
    tick();
    out_ready = 1'b0;
    in_op = 4'd2; in_a = 32'hF0F0; in_b = 32'h0FF0; in_ovf_en = 1'b0; in_valid = 1'b1;
    tick();
    in_op = 4'd3; in_a = 32'h1; in_b = 32'h2;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'h00F0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc=%0d v=%b res=%h rdy=%b required 1 000000F0 0", i, out_valid, out_result, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready got=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h3) begin
      errors++; $display("FAIL bp_next v=%b res=%h required 1 00000003", out_valid, out_result);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain v=%b required 0", out_valid);
    end
  endtask

  task automatic test_flush();
    int lat;
    do_op(4'd14, 32'hAAAA, 32'h0, 1'b0, lat);
    do_op(4'd15, 32'h5555, 32'h0, 1'b0, lat);
    in_op = 4'd11; in_a = 32'd100; in_b = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_div0 !== 1'b0) begin
      errors++; $display("FAIL flush_state rdy=%b v=%b div0=%b required 1 0 0", in_ready, out_valid, out_div0);
    end
    repeat (40) tick();
    checks++;
    if (hi !== 32'hAAAA || lo !== 32'h5555 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_hilo hi=%h lo=%h v=%b required AAAA 5555 0", hi, lo, out_valid);
    end
    do_op(4'd13, 32'h0, 32'h0, 1'b0, lat);
    checks++;
    if (out_result !== 32'h5555) begin
      errors++; $display("FAIL flush_mflo res=%h required 00005555", out_result);
    end
    in_op = 4'd0; in_a = 32'h1; in_b = 32'h1; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_drops_accept v=%b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    in_op = 4'd14; in_a = 32'h1234; in_b = 32'h0; in_valid = 1'b1;
    tick();
    in_op = 4'd12; in_a = 32'h0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h0 || hi !== 32'h1234 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mthi v=%b res=%h hi=%h rdy=%b required 1 0 1234 1", out_valid, out_result, hi, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h1234) begin
      errors++; $display("FAIL mfhi_b2b v=%b res=%h required 1 00001234", out_valid, out_result);
    end
  endtask

  task automatic test_reset_busy();
    in_op = 4'd8; in_a = 32'h7; in_b = 32'h9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({out_valid, out_ovf, out_div0, in_ready} !== 4'b0001 || {out_result, hi, lo} !== 96'h0) begin
      errors++; $display("FAIL reset_busy flags=%b res=%h hi=%h lo=%h required 0001 0 0 0",
                         {out_valid, out_ovf, out_div0, in_ready}, out_result, hi, lo);
    end
    repeat (40) tick();
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_busy_late hi=%h lo=%h v=%b required 0 0 0", hi, lo, out_valid);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_add_ovf();
    test_mult();
    test_div();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
